spi_xfer_seq: RTL and testbench

- Hardware transaction sequencer for the SPI master core; replaces per-byte Picoblaze polling for PmodACL2 (ADXL362) register access.
- One start request runs a full command/address/data burst: drives ncs_o, pushes bytes into the core write FIFO (wfwe/wfdin), waits on status (spsr), pops the read FIFO (rfre/rfdout), and streams read data back.
- Sits between the Picoblaze register front-end and the SPI core, on the same clock.

---
 rtl/spi_seq_pkg.sv | 23 ++
 rtl/spi_cs_timer.sv | 29 ++
 rtl/spi_xfer_seq.sv | 197 +++++++++++++++++++
 tb/tb_spi_xfer_seq.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared states, command bytes and status bit positions for the SPI sequencer
package spi_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        PUSH,
        WAIT,
        POP,
        HOLD,
        DONE
    } state_t;

    localparam logic [7:0] CMD_WR_DEF = 8'h0A;
    localparam logic [7:0] CMD_RD_DEF = 8'h0B;

    localparam int SPSR_RFEMPTY = 0;
    localparam int SPSR_WFFULL  = 3;

    localparam int CS_TMR_W = 8;

endpackage

// File: rtl/spi_cs_timer.sv
// rtl/spi_cs_timer.sv - loadable down-counter with terminal flag for chip-select setup/hold
module spi_cs_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt;

    // Loading N-1 makes the terminal flag rise after exactly N cycles in the waiting state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/spi_xfer_seq.sv
// rtl/spi_xfer_seq.sv - command/address/data burst sequencer driving the SPI master core FIFOs
module spi_xfer_seq
    import spi_seq_pkg::*;
#(
    parameter int         LEN_W    = 4,
    parameter int         CS_SETUP = 2,
    parameter int         CS_HOLD  = 2,
    parameter logic [7:0] CMD_WR   = CMD_WR_DEF,
    parameter logic [7:0] CMD_RD   = CMD_RD_DEF
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             rw,
    input  logic [7:0]       addr,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    input  logic [7:0]       spsr,
    input  logic [7:0]       rfdout,
    output logic             wfwe,
    output logic [7:0]       wfdin,
    output logic             rfre,
    output logic             ncs_o
);

    localparam logic [CS_TMR_W-1:0] SETUP_LD = CS_TMR_W'(CS_SETUP - 1);
    localparam logic [CS_TMR_W-1:0] HOLD_LD  = CS_TMR_W'(CS_HOLD - 1);
    localparam logic [LEN_W:0]      IDX_ONE  = (LEN_W + 1)'(1);
    localparam logic [LEN_W:0]      IDX_PAY  = (LEN_W + 1)'(2);

    state_t             state, state_d;
    logic               rw_q, rw_d;
    logic [7:0]         addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W:0]     idx, idx_d;
    logic [LEN_W:0]     last_idx;
    logic [7:0]         tx_byte, tx_d;
    logic               busy_d, ncs_d, wfwe_d, rfre_d, wr_ready_d, rd_valid_d, done_d;
    logic [7:0]         wfdin_d, rd_data_d;
    logic               tmr_load, tmr_tc;
    logic [CS_TMR_W-1:0] tmr_val;

    assign last_idx = {1'b0, len_q} + IDX_ONE;

    spi_cs_timer #(
        .W (CS_TMR_W)
    ) u_cs_timer (
        .clk      (clk),
        .nrst     (nrst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            rw_q     <= 1'b0;
            addr_q   <= 8'h00;
            len_q    <= '0;
            idx      <= '0;
            tx_byte  <= 8'h00;
            busy     <= 1'b0;
            ncs_o    <= 1'b1;
            wfwe     <= 1'b0;
            wfdin    <= 8'h00;
            rfre     <= 1'b0;
            wr_ready <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            idx      <= idx_d;
            tx_byte  <= tx_d;
            busy     <= busy_d;
            ncs_o    <= ncs_d;
            wfwe     <= wfwe_d;
            wfdin    <= wfdin_d;
            rfre     <= rfre_d;
            wr_ready <= wr_ready_d;
            rd_valid <= rd_valid_d;
            rd_data  <= rd_data_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d    = state;
        rw_d       = rw_q;
        addr_d     = addr_q;
        len_d      = len_q;
        idx_d      = idx;
        tx_d       = tx_byte;
        busy_d     = busy;
        ncs_d      = ncs_o;
        wfdin_d    = wfdin;
        rd_data_d  = rd_data;
        wfwe_d     = 1'b0;
        rfre_d     = 1'b0;
        wr_ready_d = 1'b0;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    rw_d     = rw;
                    addr_d   = addr;
                    len_d    = len;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    ncs_d    = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (tmr_tc) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (idx == '0) begin
                    tx_d    = rw_q ? CMD_RD : CMD_WR;
                    state_d = PUSH;
                end else if (idx == IDX_ONE) begin
                    tx_d    = addr_q;
                    state_d = PUSH;
                end else if (rw_q) begin
                    tx_d    = 8'h00;
                    state_d = PUSH;
                end else if (wr_valid) begin
                    // The ready strobe lands the cycle after capture; the source holds data until it sees it.
                    tx_d       = wr_data;
                    wr_ready_d = 1'b1;
                    state_d    = PUSH;
                end
            end
            PUSH: begin
                if (!spsr[SPSR_WFFULL]) begin
                    wfwe_d  = 1'b1;
                    wfdin_d = tx_byte;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!spsr[SPSR_RFEMPTY]) begin
                    state_d = POP;
                end
            end
            POP: begin
                rfre_d = 1'b1;
                // Command/address echoes and write-payload echoes are dropped.
                if (rw_q && (idx >= IDX_PAY)) begin
                    rd_data_d  = rfdout;
                    rd_valid_d = 1'b1;
                end
                idx_d = idx + IDX_ONE;
                if (idx == last_idx) begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                    state_d  = HOLD;
                end else begin
                    state_d = LOAD;
                end
            end
            HOLD: begin
                if (tmr_tc) begin
                    ncs_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb/tb_spi_xfer_seq.sv - scoreboard bench for spi_xfer_seq with a reactive SPI core FIFO model
module tb_spi_xfer_seq;

    localparam int LEN_W    = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             start = 1'b0;
    logic             rw = 1'b0;
    logic [7:0]       addr = 8'h00;
    logic [LEN_W-1:0] len = '0;
    logic [7:0]       wr_data = 8'h00;
    logic             wr_valid = 1'b0;
    logic             wr_ready, rd_valid, busy, done, wfwe, rfre, ncs_o;
    logic [7:0]       rd_data, wfdin, spsr, rfdout;
    logic             rfempty;
    logic             wffull = 1'b0;

    always #5 clk = ~clk;

    assign spsr = {4'b0000, wffull, 2'b00, rfempty};

    spi_xfer_seq #(
        .LEN_W    (LEN_W),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .start    (start),
        .rw       (rw),
        .addr     (addr),
        .len      (len),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done),
        .spsr     (spsr),
        .rfdout   (rfdout),
        .wfwe     (wfwe),
        .wfdin    (wfdin),
        .rfre     (rfre),
        .ncs_o    (ncs_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_push[$];
    logic [7:0] exp_rd[$];
    logic [7:0] slave_q[$];
    logic [7:0] wr_q[$];
    logic [7:0] pay[16];
    logic [7:0] slv[18];

    int  lat = 2;
    bit  pending;
    int  mcnt;
    bit  wr_hold = 1'b0;
    int  bp_delay = 0;
    int  bp_len = 0;

    // Core model: one byte shifts out lat+1 cycles after the push, then sits in the read FIFO until popped.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rfempty <= 1'b1;
            pending <= 1'b0;
            mcnt    <= 0;
            rfdout  <= 8'h00;
        end else begin
            if (rfre) rfempty <= 1'b1;
            if (wfwe) begin
                pending <= 1'b1;
                mcnt    <= lat;
            end else if (pending) begin
                if (mcnt == 0) begin
                    pending <= 1'b0;
                    rfempty <= 1'b0;
                    if (slave_q.size() != 0) rfdout <= slave_q.pop_front();
                    else rfdout <= 8'hEE;
                end else begin
                    mcnt <= mcnt - 1;
                end
            end
        end
    end

    int   push_cnt, rfre_cnt, rdv_cnt, wrr_cnt, done_cnt, viol, ncs_low;
    int   cyc = 0;
    int   rise_cyc = 0;
    int   done_gap = 0;
    logic prev_ncs = 1'b1;
    logic full_at_edge = 1'b0;

    always @(posedge clk) full_at_edge = wffull;

    always @(negedge clk) begin
        cyc++;
        if (nrst) begin
            if (wfwe) begin
                push_cnt++;
                if (full_at_edge) viol++;
                if (pending || !rfempty) viol++;
                check("push_expected", exp_push.size() != 0, 1'b1);
                if (exp_push.size() != 0) check("wfdin", wfdin, exp_push.pop_front());
            end
            if (rfre) begin
                rfre_cnt++;
                if (rfempty) viol++;
            end
            if (rd_valid) begin
                rdv_cnt++;
                check("rd_expected", exp_rd.size() != 0, 1'b1);
                if (exp_rd.size() != 0) check("rd_data", rd_data, exp_rd.pop_front());
            end
            if (wr_ready) wrr_cnt++;
            if (done) begin
                done_cnt++;
                done_gap = cyc - rise_cyc;
            end
            if (!ncs_o) ncs_low++;
            if (ncs_o && !prev_ncs) rise_cyc = cyc;
        end
        prev_ncs = ncs_o;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (wr_ready && wr_q.size() != 0) void'(wr_q.pop_front());
            if (!wr_hold && wr_q.size() != 0) begin
                wr_valid = 1'b1;
                wr_data  = wr_q[0];
            end else begin
                wr_valid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bp_delay > 0) begin
                bp_delay--;
                wffull = 1'b0;
            end else if (bp_len > 0) begin
                wffull = 1'b1;
                bp_len--;
            end else begin
                wffull = 1'b0;
            end
        end
    end

    task automatic clear_counts();
        push_cnt = 0; rfre_cnt = 0; rdv_cnt = 0; wrr_cnt = 0;
        done_cnt = 0; viol = 0; ncs_low = 0; done_gap = 0;
    endtask

    task automatic do_xfer(input bit r, input logic [7:0] a, input int n,
                           input bit hold_wr, input bit extra_start);
        int bad;
        @(negedge clk);
        #1;
        clear_counts();
        wr_hold = hold_wr;
        exp_push.push_back(r ? 8'h0B : 8'h0A);
        exp_push.push_back(a);
        for (int i = 0; i < n; i++) begin
            exp_push.push_back(r ? 8'h00 : pay[i]);
            if (!r) wr_q.push_back(pay[i]);
            else exp_rd.push_back(slv[i + 2]);
        end
        for (int i = 0; i < n + 2; i++) slave_q.push_back(slv[i]);
        start = 1'b1; rw = r; addr = a; len = n[LEN_W-1:0];
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("ncs_after_start", ncs_o, 1'b0);
        if (extra_start) begin
            repeat (3) @(negedge clk);
            start = 1'b1; rw = ~r; addr = 8'hFF; len = 4'd3;
            @(negedge clk);
            start = 1'b0;
        end
        if (hold_wr) begin
            for (int k = 0; k < 500 && rfre_cnt < 2; k++) @(negedge clk);
            check("stall_reached", rfre_cnt, 2);
            bad = 0;
            repeat (20) begin
                @(negedge clk);
                if (ncs_o !== 1'b0 || wfwe !== 1'b0) bad++;
            end
            check("stall_quiet", bad, 0);
            check("stall_no_wr_ready", wrr_cnt, 0);
            wr_hold = 1'b0;
        end
        for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("done_count", done_cnt, 1);
        check("push_count", push_cnt, n + 2);
        check("push_queue_empty", exp_push.size(), 0);
        check("rd_queue_empty", exp_rd.size(), 0);
        check("rfre_count", rfre_cnt, n + 2);
        check("rd_valid_count", rdv_cnt, r ? n : 0);
        check("wr_ready_count", wrr_cnt, r ? 0 : n);
        check("done_gap", done_gap, 1);
        check("ncs_low_min", ncs_low >= CS_SETUP + CS_HOLD + 3 * (n + 2), 1'b1);
        check("handshake_viol", viol, 0);
        check("idle_ncs", ncs_o, 1'b1);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        clear_counts();
        repeat (3) @(negedge clk);
        check("rst_ncs", ncs_o, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_wfwe", wfwe, 1'b0);
        check("rst_rfre", rfre, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_wfdin", wfdin, 8'h00);
        check("rst_rd_data", rd_data, 8'h00);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        lat = 2;
        slv[0] = 8'hA5; slv[1] = 8'hA5; slv[2] = 8'hAD;
        do_xfer(1'b1, 8'h00, 1, 1'b0, 1'b0);

        pay[0] = 8'h02;
        slv[0] = 8'h11; slv[1] = 8'h22; slv[2] = 8'h33;
        do_xfer(1'b0, 8'h2D, 1, 1'b0, 1'b0);

        slv[0] = 8'hFF; slv[1] = 8'hFF;
        for (int i = 0; i < 6; i++) slv[i + 2] = 8'(i + 1);
        do_xfer(1'b1, 8'h0E, 6, 1'b0, 1'b1);

        pay[0] = 8'h11; pay[1] = 8'h22;
        for (int i = 0; i < 4; i++) slv[i] = 8'h5A;
        do_xfer(1'b0, 8'h1F, 2, 1'b1, 1'b0);

        lat = 8;
        bp_delay = 2; bp_len = 6;
        slv[0] = 8'h00; slv[1] = 8'h00; slv[2] = 8'hC3; slv[3] = 8'h3C;
        do_xfer(1'b1, 8'h05, 2, 1'b0, 1'b0);

        lat = 1;
        slv[0] = 8'h77; slv[1] = 8'h88;
        do_xfer(1'b1, 8'h07, 0, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) pay[i] = 8'(i * 17 + 3);
        for (int i = 0; i < 17; i++) slv[i] = 8'h99;
        do_xfer(1'b0, 8'h20, 15, 1'b0, 1'b0);

        // Abort a read while byte 1 is in flight.
        lat = 6;
        @(negedge clk);
        #1;
        clear_counts();
        exp_push.push_back(8'h0B);
        exp_push.push_back(8'h03);
        for (int i = 0; i < 4; i++) slave_q.push_back(8'h44);
        start = 1'b1; rw = 1'b1; addr = 8'h03; len = 4'd2;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 500 && push_cnt < 2; k++) @(negedge clk);
        check("abort_reached", push_cnt, 2);
        #2;
        nrst = 1'b0;
        #1;
        check("rst_async_ncs", ncs_o, 1'b1);
        check("rst_async_busy", busy, 1'b0);
        @(negedge clk);
        exp_push.delete(); exp_rd.delete(); slave_q.delete(); wr_q.delete();
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (10) @(negedge clk);
        check("no_done_after_abort", done_cnt, 0);
        check("ncs_idle_after_abort", ncs_o, 1'b1);

        lat = 2;
        pay[0] = 8'hB7; pay[1] = 8'h4E;
        for (int i = 0; i < 4; i++) slv[i] = 8'h12;
        do_xfer(1'b0, 8'h2C, 2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
